// File: rtl/risc32_btn_ctrl_pkg.sv
// Shared definitions for the risc32 button controller: io register offsets
// and the default debounce window.
package risc32_btn_ctrl_pkg;

   typedef enum logic [1:0] {
      BTN_REG_LEVEL   = 2'd0,
      BTN_REG_PRESS   = 2'd1,
      BTN_REG_RELEASE = 2'd2,
      BTN_REG_INTEN   = 2'd3
   } btn_reg_e;

   // 10 ms at 100 MHz
   localparam int BTN_STABLE_CNT_DFLT = 1000000;

endpackage

// File: rtl/risc32_debounce_ch.sv
// One button channel: input synchroniser, stability counter, debounced
// level and single-cycle rise/fall pulses aligned with the level change.
module risc32_debounce_ch #(
   parameter int CNT_W       = 20,
   parameter int STABLE_CNT  = 1000000,
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_i,
   output logic level_o,
   output logic rise_o,
   output logic fall_o
);

   localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(STABLE_CNT - 1);

   logic [SYNC_STAGES-1:0] r_sync;
   logic [CNT_W-1:0]       r_cnt;
   logic                   r_level;
   logic                   r_diff;
   logic                   w_sync;
   logic                   w_diff;
   logic                   w_done;

   assign w_sync = r_sync[SYNC_STAGES-1];
   assign w_diff = w_sync ^ r_level;
   assign w_done = w_diff & r_diff & (r_cnt == LP_LAST);

   // Shift the raw input through the synchroniser chain
   always_ff @(posedge clk) begin
      if (rst) r_sync <= '0;
      else     r_sync <= {r_sync[SYNC_STAGES-2:0], btn_i};
   end

   // Count consecutive mismatching cycles and accept the new level at the window end.
   // The mismatch must be seen on two consecutive edges before counting starts,
   // which places the level change SYNC_STAGES + STABLE_CNT edges after sampling.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt   <= '0;
         r_level <= 1'b0;
         r_diff  <= 1'b0;
      end else begin
         r_diff <= w_diff & ~w_done;
         if (!w_diff) begin
            r_cnt <= '0;
         end else if (r_diff) begin
            if (w_done) begin
               r_cnt   <= '0;
               r_level <= w_sync;
            end else begin
               r_cnt <= r_cnt + CNT_W'(1);
            end
         end
      end
   end

   assign level_o = r_level;
   assign rise_o  = w_done &  w_sync;
   assign fall_o  = w_done & ~w_sync;

endmodule

// File: rtl/risc32_btn_ctrl.sv
// N-channel button controller for the risc32 io space: per-channel debounce,
// latched press/release events (W1C), interrupt enables and a registered IRQ.
module risc32_btn_ctrl
   import risc32_btn_ctrl_pkg::*;
#(
   parameter int N_CH        = 5,
   parameter int CNT_W       = 20,
   parameter int STABLE_CNT  = BTN_STABLE_CNT_DFLT,
   parameter int SYNC_STAGES = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N_CH-1:0] btn_i,
   input  logic            ce_i,
   input  logic            we_i,
   input  logic [1:0]      addr_i,
   input  logic [31:0]     data_i,
   output logic [31:0]     data_o,
   output logic [N_CH-1:0] level_o,
   output logic            int_o
);

   logic [N_CH-1:0] w_level;
   logic [N_CH-1:0] w_rise;
   logic [N_CH-1:0] w_fall;
   logic [N_CH-1:0] w_wdata;
   logic [N_CH-1:0] w_clr_press;
   logic [N_CH-1:0] w_clr_release;
   logic            w_wr;
   logic            w_rd;
   logic            w_unused;
   btn_reg_e        w_addr;

   logic [N_CH-1:0] r_press;
   logic [N_CH-1:0] r_release;
   logic [N_CH-1:0] r_inten;
   logic            r_int;

   for (genvar g = 0; g < N_CH; g++) begin : g_ch
      risc32_debounce_ch #(
         .CNT_W       (CNT_W),
         .STABLE_CNT  (STABLE_CNT),
         .SYNC_STAGES (SYNC_STAGES)
      ) u_ch (
         .clk     (clk),
         .rst     (rst),
         .btn_i   (btn_i[g]),
         .level_o (w_level[g]),
         .rise_o  (w_rise[g]),
         .fall_o  (w_fall[g])
      );
   end

   assign w_wr     = ce_i & we_i;
   assign w_rd     = ce_i & ~we_i;
   assign w_addr   = btn_reg_e'(addr_i);
   assign w_wdata  = data_i[N_CH-1:0];
   assign w_unused = ^data_i;

   assign w_clr_press   = (w_wr && w_addr == BTN_REG_PRESS)   ? w_wdata : '0;
   assign w_clr_release = (w_wr && w_addr == BTN_REG_RELEASE) ? w_wdata : '0;

   // Event latches (set beats clear), interrupt enables and the IRQ register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_press   <= '0;
         r_release <= '0;
         r_inten   <= '0;
         r_int     <= 1'b0;
      end else begin
         r_press   <= (r_press   & ~w_clr_press)   | w_rise;
         r_release <= (r_release & ~w_clr_release) | w_fall;
         if (w_wr && w_addr == BTN_REG_INTEN) r_inten <= w_wdata;
         r_int <= |((r_press | r_release) & r_inten);
      end
   end

   // Combinational read mux, zero outside a read cycle
   always_comb begin
      data_o = '0;
      if (w_rd) begin
         case (w_addr)
            BTN_REG_LEVEL:   data_o = 32'(w_level);
            BTN_REG_PRESS:   data_o = 32'(r_press);
            BTN_REG_RELEASE: data_o = 32'(r_release);
            BTN_REG_INTEN:   data_o = 32'(r_inten);
         endcase
      end
   end

   assign level_o = w_level;
   assign int_o   = r_int;

endmodule

// File: tb/tb_risc32_btn_ctrl.sv
// Directed bench for risc32_btn_ctrl with N_CH=5, STABLE_CNT=4, SYNC_STAGES=2.
// Inputs change 1 time unit after a rising edge; the first edge that samples
// a change is called e0 and the level is expected to move on edge e0+6.
module tb_risc32_btn_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  btn_i;
   logic        ce_i;
   logic        we_i;
   logic [1:0]  addr_i;
   logic [31:0] data_i;
   logic [31:0] data_o;
   logic [4:0]  level_o;
   logic        int_o;

   int n_chk  = 0;
   int n_fail = 0;

   risc32_btn_ctrl #(
      .N_CH        (5),
      .CNT_W       (20),
      .STABLE_CNT  (4),
      .SYNC_STAGES (2)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .btn_i   (btn_i),
      .ce_i    (ce_i),
      .we_i    (we_i),
      .addr_i  (addr_i),
      .data_i  (data_i),
      .data_o  (data_o),
      .level_o (level_o),
      .int_o   (int_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      ce_i   = 1'b1;
      we_i   = 1'b1;
      addr_i = a;
      data_i = d;
      tick();
      ce_i   = 1'b0;
      we_i   = 1'b0;
      data_i = '0;
   endtask

   task automatic rd(input logic [1:0] a, output logic [31:0] d);
      ce_i   = 1'b1;
      we_i   = 1'b0;
      addr_i = a;
      #1;
      d      = data_o;
      ce_i   = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] v;
      logic        seen;

      rst = 1'b1; btn_i = '0; ce_i = 1'b0; we_i = 1'b0; addr_i = '0; data_i = '0;
      repeat (3) tick();

      // Reset state
      chk("rst_level", 32'(level_o), 32'h0);
      chk("rst_int", 32'(int_o), 32'h0);
      rd(2'd1, v); chk("rst_press", v, 32'h0);
      rd(2'd3, v); chk("rst_inten", v, 32'h0);
      rst = 1'b0;
      tick();

      // Clean press on channel 2 with its interrupt enabled
      wr(2'd3, 32'h04);
      btn_i[2] = 1'b1;
      repeat (6) tick();
      chk("press_lvl_early", 32'(level_o), 32'h0);
      tick();
      chk("press_lvl", 32'(level_o), 32'h04);
      rd(2'd1, v); chk("press_reg", v, 32'h04);
      chk("press_int_lat", 32'(int_o), 32'h0);
      tick();
      chk("press_int", 32'(int_o), 32'h1);
      rd(2'd0, v); chk("level_reg", v, 32'h04);
      wr(2'd1, 32'h04);
      rd(2'd1, v); chk("press_w1c", v, 32'h0);
      chk("w1c_int_hold", 32'(int_o), 32'h1);
      tick();
      chk("w1c_int_fall", 32'(int_o), 32'h0);

      // Release of channel 2 collides with a W1C of RELEASE on the same edge
      btn_i[2] = 1'b0;
      repeat (6) tick();
      chk("rel_lvl_early", 32'(level_o), 32'h04);
      wr(2'd2, 32'h04);
      chk("rel_lvl", 32'(level_o), 32'h0);
      rd(2'd2, v); chk("collide_set_wins", v, 32'h04);
      tick();
      chk("rel_int", 32'(int_o), 32'h1);
      wr(2'd2, 32'h04);
      rd(2'd2, v); chk("rel_w1c", v, 32'h0);
      tick();
      chk("rel_int_fall", 32'(int_o), 32'h0);

      // Bounce rejection on channel 0
      seen = 1'b0;
      for (int unsigned i = 0; i < 5; i++) begin
         btn_i[0] = 1'b1;
         repeat (3) begin tick(); seen = seen | level_o[0]; end
         btn_i[0] = 1'b0;
         tick(); seen = seen | level_o[0];
      end
      repeat (3) begin tick(); seen = seen | level_o[0]; end
      chk("bounce_no_level", 32'(seen), 32'h0);
      rd(2'd1, v); chk("bounce_no_press", v, 32'h0);
      btn_i[0] = 1'b1;
      repeat (6) tick();
      rd(2'd1, v); chk("bounce_press_early", v, 32'h0);
      tick();
      rd(2'd1, v); chk("bounce_press", v, 32'h01);
      tick();
      chk("bounce_int_masked", 32'(int_o), 32'h0);

      // Multi-channel simultaneous press
      btn_i = '0;
      repeat (10) tick();
      wr(2'd1, 32'h1F);
      wr(2'd2, 32'h1F);
      rd(2'd2, v); chk("multi_clr", v, 32'h0);
      btn_i = 5'b10101;
      repeat (6) tick();
      rd(2'd1, v); chk("multi_early", v, 32'h0);
      tick();
      rd(2'd1, v); chk("multi_press", v, 32'h15);
      wr(2'd1, 32'h05);
      rd(2'd1, v); chk("multi_partial_w1c", v, 32'h10);

      // Reset in the middle of a debounce count on channel 1
      btn_i = 5'b00010;
      repeat (4) tick();
      rst = 1'b1;
      repeat (2) tick();
      chk("mid_rst_level", 32'(level_o), 32'h0);
      chk("mid_rst_int", 32'(int_o), 32'h0);
      rd(2'd1, v); chk("mid_rst_press", v, 32'h0);
      rd(2'd2, v); chk("mid_rst_release", v, 32'h0);
      rd(2'd3, v); chk("mid_rst_inten", v, 32'h0);
      rst = 1'b0;
      repeat (6) tick();
      rd(2'd1, v); chk("post_rst_early", v, 32'h0);
      tick();
      rd(2'd1, v); chk("post_rst_press", v, 32'h02);
      chk("post_rst_level", 32'(level_o), 32'h02);

      // Bus hygiene
      wr(2'd0, 32'hFFFF_FFFF);
      wr(2'd3, 32'hFFFF_FFFF);
      rd(2'd0, v); chk("level_ro", v, 32'h02);
      rd(2'd3, v); chk("inten_mask", v, 32'h1F);
      tick();
      chk("inten_int", 32'(int_o), 32'h1);
      ce_i = 1'b0; we_i = 1'b0; addr_i = 2'd3;
      #1; chk("no_ce_read", data_o, 32'h0);
      ce_i = 1'b1; we_i = 1'b1; addr_i = 2'd3;
      #1; chk("write_cycle_read", data_o, 32'h0);
      ce_i = 1'b0; we_i = 1'b0;
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/risc32_btn_ctrl.md
# risc32_btn_ctrl

Parametrised N-channel button controller for the risc32 I/O space: it debounces N raw push-button inputs, latches press and release events, and exposes level, event and interrupt-enable registers to the CPU over the io bus. It generalises the fixed 5-button, level-only debounce path, adding channel count, programmable stability window, edge events and an interrupt output. Its `int_o` drives one bit of the CPU `int_i` vector.

## Interface
Parameters:
- `N_CH`, 5: number of button channels, 1..32.
- `CNT_W`, 20: debounce counter width.
- `STABLE_CNT`, 1000000: consecutive stable cycles required to accept a new level. Range 1..2^CNT_W−1. 10 ms at 100 MHz.
- `SYNC_STAGES`, 2: synchroniser depth, ≥2.

Ports:
- `clk` in 1: single system clock.
- `rst` in 1: synchronous, active-high reset.
- `btn_i` in N_CH: raw asynchronous button inputs, active-high.
- `ce_i` in 1: io bus select for this block.
- `we_i` in 1: write strobe, valid with `ce_i`.
- `addr_i` in 2: register select (word index).
- `data_i` in 32: write data.
- `data_o` out 32: read data.
- `level_o` out N_CH: debounced levels, for direct fabric use.
- `int_o` out 1: registered interrupt request, active-high, level-sensitive.

## Operation
- Per channel:
  - Inputs pass through a `SYNC_STAGES`-flop synchroniser giving `sync`.
  - A counter runs while `sync != level`. If `sync == level`, the counter is cleared to 0.
  - When the counter equals `STABLE_CNT−1` with `sync != level`:
    - `level` takes `sync` and the counter clears.
    - A 0→1 transition sets `PRESS[ch]`; a 1→0 transition sets `RELEASE[ch]`.
  - Any glitch shorter than `STABLE_CNT` cycles restarts the count and produces no event.
- Register map (`addr_i`):
  - 0 LEVEL, RO: bits [N_CH−1:0] = `level_o`.
  - 1 PRESS, W1C: latched press events.
  - 2 RELEASE, W1C: latched release events.
  - 3 INT_EN, RW: per-channel interrupt enable, bits [N_CH−1:0].
- Reads:
  - Combinational: `data_o` = selected register when `ce_i & ~we_i`, else 0.
  - Bits ≥ N_CH read 0.
- Writes:
  - Take effect on the `clk` edge with `ce_i & we_i`.
  - Writes to LEVEL are ignored.
  - Bits ≥ N_CH are ignored.
- Event set vs. W1C clear in the same cycle: set wins and the bit stays 1.
- `int_o` is a register: next = |((PRESS | RELEASE) & INT_EN).

## Timing
- Reset state:
  - Synchroniser flops, counters, `level_o`, PRESS, RELEASE, INT_EN and `int_o` are all 0.
  - `data_o` is 0 unless a read is presented.
- Reset mid-debounce discards the count and level. No event is generated after reset, even if `btn_i` is held high: the press event appears only after the full window from the release of `rst`.
- Press latency:
  - `level_o` changes exactly `SYNC_STAGES + STABLE_CNT` cycles after the first edge that samples the new `btn_i` value, provided the input holds stable.
  - PRESS/RELEASE set on the same edge as the `level_o` change.
  - `int_o` rises one cycle later.
- Clearing:
  - After a W1C clear of the last pending enabled event, `int_o` falls one cycle after the write edge.
  - Setting INT_EN while an event is pending raises `int_o` one cycle after the write edge.
- `STABLE_CNT=1`: level follows `sync` with one cycle of added delay.
- The counter never wraps, because it clears at `STABLE_CNT−1`.

## Structure
- Add to `risc32_consts.v`: register offsets `BTN_REG_LEVEL`/`PRESS`/`RELEASE`/`INTEN` (2'd0..2'd3) and the default `STABLE_CNT`.
- Sub-module `risc32_debounce_ch`:
  - One channel: synchroniser, counter, level, and 1-cycle `rise`/`fall` pulses.
  - Instantiated N_CH times in a generate loop.
- Top level holds the register file, bus decode and `int_o`.

## Test plan
All scenarios use `N_CH=5`, `STABLE_CNT=4`, `SYNC_STAGES=2`.
- Clean press: `btn_i[2]` held high from cycle 10 → `level_o[2]` and `PRESS[2]` = 1 at cycle 16. With INT_EN=0x04, `int_o`=1 at cycle 17. Read addr 1 returns 0x00000004.
- Bounce rejection: `btn_i[0]` toggles high 3 cycles, low 1 cycle, repeated 5 times, then holds high → no event during bouncing. PRESS[0] sets 6 cycles after the final rise.
- W1C/set collision: write 0x01 to addr 2 on the same edge that RELEASE[0] sets → RELEASE[0] reads 1 afterwards. A second write clears it, and `int_o` falls 1 cycle later.
- Multi-channel: `btn_i`=5'b10101 simultaneously → PRESS reads 0x15 at cycle +6. Writing 0x05 to addr 1 leaves 0x10.
- Reset mid-debounce: assert `rst` 2 cycles into a count with `btn_i[1]` held high → all outputs 0. After `rst` drops, PRESS[1] sets 6 cycles later.
- Bus hygiene: write 0xFFFFFFFF to addr 0 and addr 3 → LEVEL unchanged, INT_EN reads 0x1F. `data_o`=0 when `ce_i`=0.
